// File: rtl/sample_framer_pkg.sv
// sample_framer_pkg: shared state encoding and address-width helper for the sample framer
package sample_framer_pkg;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/framer_ram.sv
// framer_ram: simple dual-port frame buffer, synchronous write and registered read
module framer_ram
    import sample_framer_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 14,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sample_framer.sv
// sample_framer: captures N strobed samples after start and replays them as a gap-free N-cycle burst
module sample_framer
    import sample_framer_pkg::*;
#(
    parameter int N             = 1024,
    parameter int DATA_WIDTH    = 14,
    parameter bit OFFSET_BINARY = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         din_valid,
    input  logic        [DATA_WIDTH-1:0] din,
    output logic                         dout_en,
    output logic signed [DATA_WIDTH-1:0] dout,
    output logic                         busy,
    output logic                         overrun
);

    localparam int AW = addr_w(N);
    localparam logic [DATA_WIDTH-1:0] MSB_FLIP = {OFFSET_BINARY, {(DATA_WIDTH-1){1'b0}}};

    state_t state, state_n;
    logic [AW-1:0] wcount, raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic en_q, accept, we, last_wr, drain_done;

    // en_q high with raddr wrapped back to 0 marks the final burst cycle
    always_comb begin
        accept     = state == IDLE && start;
        we         = din_valid && (accept || state == FILL);
        last_wr    = state == FILL && din_valid && &wcount;
        drain_done = state == DRAIN && en_q && raddr == '0;
        state_n    = accept ? FILL : last_wr ? DRAIN : drain_done ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcount  <= '0;
            raddr   <= '0;
            en_q    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (we) wcount <= wcount + 1'b1;
            if (state == DRAIN && !drain_done) raddr <= raddr + 1'b1;
            en_q <= state == DRAIN && !drain_done;
            if (start && state != IDLE) overrun <= 1'b1;
        end
    end

    framer_ram #(
        .DEPTH(N),
        .WIDTH(DATA_WIDTH),
        .AW   (AW)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(wcount),
        .wdata(din ^ MSB_FLIP),
        .re   (state == DRAIN),
        .raddr(raddr),
        .rdata(rdata)
    );

    assign dout_en = en_q;
    assign dout    = en_q ? $signed(rdata) : '0;
    assign busy    = state != IDLE;

endmodule

// File: doc/sample_framer.md
Name: sample_framer

Overview:
- Sits directly upstream of the windowing stage in the FFT chain.
- Captures one frame of N sparse, strobed ADC/decimator samples after a frame-start pulse, then replays them as a contiguous N-cycle burst.
- The window stage's coefficient counter advances every enabled cycle and resets whenever its enable drops, so the burst must be gap-free for coefficients to stay aligned.

Parameters:
- N, 1024, samples per frame; power of two, at least 4.
- DATA_WIDTH, 14, sample width; signed two's complement at the output.
- OFFSET_BINARY, 0, when 1 the input is offset-binary and the MSB is inverted on capture.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle frame-start pulse.
- din_valid  in  1  input sample strobe; any duty cycle, gaps allowed.
- din  in  DATA_WIDTH  input sample, qualified by din_valid.
- dout_en  out  1  high for exactly N consecutive cycles per frame; drives the window stage's enable.
- dout  out  DATA_WIDTH signed  frame sample, valid while dout_en is high.
- busy  out  1  high in FILL or DRAIN.
- overrun  out  1  sticky; set when start arrives while busy.

Behaviour:
- Reset values: dout_en=0, dout=0, busy=0, overrun=0, state=IDLE, write count=0, read address=0.
- State IDLE:
  - start=1 moves to FILL.
  - If din_valid is also high in the start cycle, that sample is written as sample 0.
  - din_valid without start is ignored.
- State FILL:
  - Each din_valid writes din, MSB-inverted when OFFSET_BINARY=1, to buffer[wcount]; wcount then increments.
  - The cycle that writes sample N-1 (cycle t) moves to DRAIN at t+1 and clears wcount.
- State DRAIN:
  - A read is issued at address 0 in cycle t+1; the buffer read is registered with 1-cycle latency.
  - dout_en=1 from t+2 through t+N+1 inclusive, with dout = sample k at cycle t+2+k.
  - At t+N+2: dout_en=0, state=IDLE, busy=0.
  - din_valid is ignored throughout DRAIN; samples are dropped, not queued.
- busy: high from the cycle after start is accepted until the cycle after the last dout_en.
- dout: forced to 0 whenever dout_en=0.
- Overrun and restart rules:
  - start while busy (FILL or DRAIN) is ignored, sets overrun, and leaves the current frame unaffected.
  - overrun clears only on rst.
  - A start arriving in the same cycle that busy falls (t+N+2) is accepted normally.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. The partial frame is discarded, and buffer contents need not be cleared.
- Widths: wcount and read address are $clog2(N) bits and wrap naturally at N; no arithmetic on sample data other than the optional MSB inversion.
- Throughput: the minimum frame period is the capture time plus N+2 cycles. Capture and drain do not overlap; this is a single buffer, not ping-pong.

Decomposition:
- Shared package holds:
  - state encoding IDLE/FILL/DRAIN as a 2-bit typedef;
  - an addr-width helper constant derived from N.
- One sub-module, framer_ram:
  - simple dual-port, N x DATA_WIDTH;
  - synchronous write port plus registered read port;
  - written to infer block RAM.
- FSM, counters and output gating stay in sample_framer.

Test Plan (N=8, DATA_WIDTH=14):
- Sparse fill, one din_valid every 3 cycles:
  - stimulus: start plus din_valid in the same cycle, din = 1..8;
  - response: dout_en high for exactly 8 consecutive cycles, dout = 1,2,...,8, first dout_en 2 cycles after the 8th strobe, busy low the cycle after.
- Offset binary, OFFSET_BINARY=1:
  - stimulus: din = 14'h2000 then 14'h0000;
  - response: dout = 0, then -8192 (14'h2000).
- Start during FILL after 3 samples:
  - response: frame continues unchanged, overrun=1 and stays 1 through the next complete frame, cleared only by rst.
- Start during DRAIN:
  - response: ignored, dout_en stays contiguous for 8 cycles, overrun=1.
- Start in the exact cycle busy falls:
  - response: accepted; second frame delivers 8 contiguous dout_en cycles with correct data.
- rst asserted during DRAIN at sample 4:
  - response: next cycle dout_en=0, dout=0, busy=0, overrun=0.
  - A following frame with din = 10..17 outputs 10..17 exactly, with no stale data.
